seq_rf_wb_arb_2x1: RTL and testbench

Writeback arbiter that merges two independent result producers onto the single write port of the 8-entry x 8-bit, two-read/one-write register file, where entry 0 is hardwired to zero.
- Each producer presents an address/data write request on a val/rdy interface.
- Round-robin arbitration picks at most one non-zero-address request per cycle and registers it into a one-entry writeback stage that drives the register-file write port.
- Writes to address 0 are accepted and discarded, and a saturating counter tracks them.

---
 rtl/seq_rf_wb_arb_2x1_if.sv | 13 +
 rtl/seq_rf_wb_arb_2x1.sv | 63 ++++++
 tb/tb_seq_rf_wb_arb_2x1.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/seq_rf_wb_arb_2x1_if.sv
// Producer-side write request channel (val/rdy handshake carrying an address/data pair).
interface seq_rf_wb_arb_2x1_if #(
    parameter int unsigned NBITS = 8,
    parameter int unsigned NADDR = 3
);
    logic             val;
    logic             rdy;
    logic [NADDR-1:0] addr;
    logic [NBITS-1:0] data;

    modport master (output val, output addr, output data, input rdy);
    modport slave  (input val, input addr, input data, output rdy);
endinterface

// File: rtl/seq_rf_wb_arb_2x1.sv
// Round-robin merge of two writeback producers onto one register-file write port;
// address-0 writes are acknowledged, discarded and counted with saturation.
module seq_rf_wb_arb_2x1 #(
    parameter int unsigned NBITS = 8,
    parameter int unsigned NADDR = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    seq_rf_wb_arb_2x1_if.slave   in0,
    seq_rf_wb_arb_2x1_if.slave   in1,
    output logic                 write_en,
    output logic [NADDR-1:0]     write_addr,
    output logic [NBITS-1:0]     write_data,
    output logic [7:0]           drop_count
);
    localparam int unsigned CNT_W = 8;

    logic             prio;
    logic             zero0_c, zero1_c;
    logic             real0_c, real1_c;
    logic             grant0_c, grant1_c;
    logic [1:0]       drop_inc_c;
    logic [CNT_W:0]   drop_sum_c;
    logic [CNT_W-1:0] drop_next_c;

    // Classify requests, arbitrate real ones, and form the saturating drop update.
    always_comb begin
        zero0_c     = in0.val && (in0.addr == '0);
        zero1_c     = in1.val && (in1.addr == '0);
        real0_c     = in0.val && (in0.addr != '0);
        real1_c     = in1.val && (in1.addr != '0);
        grant0_c    = real0_c && (!real1_c || !prio);
        grant1_c    = real1_c && (!real0_c || prio);
        in0.rdy     = reset_n && (zero0_c || grant0_c);
        in1.rdy     = reset_n && (zero1_c || grant1_c);
        drop_inc_c  = 2'(zero0_c) + 2'(zero1_c);
        drop_sum_c  = {1'b0, drop_count} + (CNT_W+1)'(drop_inc_c);
        drop_next_c = drop_sum_c[CNT_W] ? {CNT_W{1'b1}} : drop_sum_c[CNT_W-1:0];
    end

    // Writeback stage, round-robin pointer and drop counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio       <= 1'b0;
            write_en   <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            drop_count <= '0;
        end else begin
            drop_count <= drop_next_c;
            write_en   <= grant0_c || grant1_c;
            if (grant0_c) begin
                prio       <= 1'b1;
                write_addr <= in0.addr;
                write_data <= in0.data;
            end else if (grant1_c) begin
                prio       <= 1'b0;
                write_addr <= in1.addr;
                write_data <= in1.data;
            end
        end
    end
endmodule

// File: tb/tb_seq_rf_wb_arb_2x1.sv
// Directed checks of arbitration, writeback timing, zero-address drops and reset behaviour.
module tb_seq_rf_wb_arb_2x1;
    logic       clk;
    logic       reset_n;
    logic       write_en;
    logic [2:0] write_addr;
    logic [7:0] write_data;
    logic [7:0] drop_count;
    logic [7:0] rf [8];
    int         total;
    int         bad;

    seq_rf_wb_arb_2x1_if #(.NBITS(8), .NADDR(3)) in0_if ();
    seq_rf_wb_arb_2x1_if #(.NBITS(8), .NADDR(3)) in1_if ();

    seq_rf_wb_arb_2x1 #(.NBITS(8), .NADDR(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in0        (in0_if),
        .in1        (in1_if),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in register file fed by the arbiter's write port.
    always @(posedge clk) if (write_en) rf[write_addr] <= write_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [2:0] a0, input logic [7:0] d0,
                         input logic v1, input logic [2:0] a1, input logic [7:0] d1);
        @(negedge clk);
        in0_if.val = v0; in0_if.addr = a0; in0_if.data = d0;
        in1_if.val = v1; in1_if.addr = a1; in1_if.data = d1;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [2:0] a, input logic [7:0] d);
        chk({tag, "_en"},   32'(write_en),   32'(en));
        chk({tag, "_addr"}, 32'(write_addr), 32'(a));
        chk({tag, "_data"}, 32'(write_data), 32'(d));
    endtask

    logic [2:0] rr_addr [4];
    logic [7:0] rr_data [4];
    logic       rr_g1   [4];
    int         i0;
    int         i1;

    initial begin
        total = 0;
        bad   = 0;
        reset_n = 1'b0;
        in0_if.val = 1'b0; in0_if.addr = '0; in0_if.data = '0;
        in1_if.val = 1'b0; in1_if.addr = '0; in1_if.data = '0;

        // Reset held with both producers requesting
        drive(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h21);
        chk("rst_rdy0", 32'(in0_if.rdy), 32'd0);
        chk("rst_rdy1", 32'(in1_if.rdy), 32'd0);
        tick();
        chk_wr("rst_wr", 1'b0, 3'd0, 8'h00);
        chk("rst_drop", 32'(drop_count), 32'd0);

        // Release: in0 favoured on the first edge
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_rdy0", 32'(in0_if.rdy), 32'd1);
        chk("rel_rdy1", 32'(in1_if.rdy), 32'd0);
        tick();
        chk_wr("rel_wr", 1'b1, 3'd1, 8'h11);

        // Idle: write_en drops, addr/data hold
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        tick();
        chk_wr("idle_wr", 1'b0, 3'd1, 8'h11);

        // Single producer back-to-back
        drive(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00);
        chk("sp0_rdy0", 32'(in0_if.rdy), 32'd1);
        tick();
        chk_wr("sp0_wr", 1'b1, 3'd3, 8'h5A);
        drive(1'b1, 3'd5, 8'hA5, 1'b0, 3'd0, 8'h00);
        chk("sp1_rdy0", 32'(in0_if.rdy), 32'd1);
        tick();
        chk_wr("sp1_wr", 1'b1, 3'd5, 8'hA5);

        // Lone in1 grant steers prio back to in0
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'h70);
        chk("lone1_rdy1", 32'(in1_if.rdy), 32'd1);
        tick();
        chk_wr("lone1_wr", 1'b1, 3'd7, 8'h70);

        // Round-robin contention: in0, in1, in0, in1
        rr_g1[0] = 1'b0; rr_addr[0] = 3'd1; rr_data[0] = 8'h11;
        rr_g1[1] = 1'b1; rr_addr[1] = 3'd2; rr_data[1] = 8'h21;
        rr_g1[2] = 1'b0; rr_addr[2] = 3'd1; rr_data[2] = 8'h12;
        rr_g1[3] = 1'b1; rr_addr[3] = 3'd2; rr_data[3] = 8'h22;
        i0 = 0;
        i1 = 0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 3'd1, 8'(8'h11 + i0), 1'b1, 3'd2, 8'(8'h21 + i1));
            chk($sformatf("rr%0d_rdy0", k), 32'(in0_if.rdy), 32'(!rr_g1[k]));
            chk($sformatf("rr%0d_rdy1", k), 32'(in1_if.rdy), 32'(rr_g1[k]));
            tick();
            chk_wr($sformatf("rr%0d_wr", k), 1'b1, rr_addr[k], rr_data[k]);
            if (rr_g1[k]) i1++; else i0++;
        end

        // Same-address conflict: in0 first, in1 held pending then written
        drive(1'b1, 3'd4, 8'hAA, 1'b1, 3'd4, 8'hBB);
        chk("conf_rdy0", 32'(in0_if.rdy), 32'd1);
        chk("conf_rdy1", 32'(in1_if.rdy), 32'd0);
        tick();
        chk_wr("conf_wr0", 1'b1, 3'd4, 8'hAA);
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'hBB);
        chk("conf_rdy1b", 32'(in1_if.rdy), 32'd1);
        tick();
        chk_wr("conf_wr1", 1'b1, 3'd4, 8'hBB);
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        tick();
        chk("conf_rf4", 32'(rf[4]), 32'h000000BB);

        // Mixed zero-address and real request
        drive(1'b1, 3'd0, 8'h77, 1'b1, 3'd6, 8'h66);
        chk("mix_rdy0", 32'(in0_if.rdy), 32'd1);
        chk("mix_rdy1", 32'(in1_if.rdy), 32'd1);
        tick();
        chk_wr("mix_wr", 1'b1, 3'd6, 8'h66);
        chk("mix_drop", 32'(drop_count), 32'd1);

        // Double drops and saturation at 255
        drive(1'b1, 3'd0, 8'h00, 1'b1, 3'd0, 8'h00);
        chk("dz_rdy0", 32'(in0_if.rdy), 32'd1);
        chk("dz_rdy1", 32'(in1_if.rdy), 32'd1);
        tick();
        chk("dz_drop3", 32'(drop_count), 32'd3);
        chk("dz_we", 32'(write_en), 32'd0);
        repeat (125) tick();
        chk("dz_drop253", 32'(drop_count), 32'd253);
        tick();
        chk("dz_sat", 32'(drop_count), 32'd255);
        repeat (73) tick();
        chk("dz_hold", 32'(drop_count), 32'd255);
        chk("dz_rf0_untouched_we", 32'(write_en), 32'd0);

        // Asynchronous reset while a write is on the port
        drive(1'b1, 3'd3, 8'h33, 1'b0, 3'd0, 8'h00);
        tick();
        chk_wr("mid_wr", 1'b1, 3'd3, 8'h33);
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        reset_n = 1'b0;
        #1;
        chk("mid_we", 32'(write_en), 32'd0);
        chk("mid_drop", 32'(drop_count), 32'd0);
        tick();
        chk("mid_rf3", 32'(rf[3]), 32'h0000005A);
        drive(1'b1, 3'd1, 8'h01, 1'b1, 3'd2, 8'h02);
        reset_n = 1'b1;
        #1;
        chk("mid_prio_rdy0", 32'(in0_if.rdy), 32'd1);
        chk("mid_prio_rdy1", 32'(in1_if.rdy), 32'd0);
        tick();
        chk_wr("mid_post_wr", 1'b1, 3'd1, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
